// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response sequencer in front of a 1-cycle registered ALU
module alu_cmd_sequencer #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_x,
   input  logic        alu_z,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_x,
   output logic        rsp_z,
   output logic        rsp_ill,
   output logic        busy
);

   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);

   logic [66:0]    cmd_mem [CMD_DEPTH];
   logic [CAW-1:0] cmd_wr, cmd_rd;
   logic [CAW:0]   cmd_count;
   logic [33:0]    rsp_mem [RSP_DEPTH];
   logic [RAW-1:0] rsp_wr, rsp_rd;
   logic [RAW:0]   rsp_count;
   logic           stage1, stage2, ill1, ill2;
   logic           push, issue, capture, pop;
   logic [66:0]    head;
   logic [RAW+1:0] credit_used;
   logic [33:0]    rsp_entry, rsp_head;

   assign head      = cmd_mem[cmd_rd];
   assign cmd_ready = !reset && (cmd_count != (CAW+1)'(CMD_DEPTH));
   assign push      = cmd_valid && cmd_ready;

   // Both in-flight stages hold a reserved response slot, so capture can never overflow.
   assign credit_used = (RAW+2)'(rsp_count) + (RAW+2)'(stage1) + (RAW+2)'(stage2);
   assign issue       = (cmd_count != '0) && (credit_used < (RAW+2)'(RSP_DEPTH));

   assign capture   = stage2;
   assign rsp_valid = (rsp_count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_entry = ill2 ? {32'd0, 1'b1, 1'b1} : {alu_x, alu_z, 1'b0};
   assign rsp_head  = rsp_mem[rsp_rd];
   assign {rsp_x, rsp_z, rsp_ill} = rsp_valid ? rsp_head : '0;
   assign busy      = (cmd_count != '0) || stage1 || stage2 || (rsp_count != '0);

   always_ff @(posedge clk) begin
      if (push) cmd_mem[cmd_wr] <= {cmd_a, cmd_b, cmd_op};
      if (capture) rsp_mem[rsp_wr] <= rsp_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_wr    <= '0;
         cmd_rd    <= '0;
         cmd_count <= '0;
      end else begin
         if (push) cmd_wr <= cmd_wr + 1'b1;
         if (issue) cmd_rd <= cmd_rd + 1'b1;
         cmd_count <= cmd_count + (CAW+1)'(push) - (CAW+1)'(issue);
      end
   end

   // ALU operand registers only load on issue, so the ALU inputs stay quiet when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
         stage1 <= 1'b0;
         stage2 <= 1'b0;
         ill1   <= 1'b0;
         ill2   <= 1'b0;
      end else begin
         if (issue) {alu_a, alu_b, alu_op} <= head;
         stage1 <= issue;
         stage2 <= stage1;
         ill1   <= issue && (head[2:0] == 3'b111);
         ill2   <= ill1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_wr    <= '0;
         rsp_rd    <= '0;
         rsp_count <= '0;
      end else begin
         if (capture) rsp_wr <= rsp_wr + 1'b1;
         if (pop) rsp_rd <= rsp_rd + 1'b1;
         rsp_count <= rsp_count + (RAW+1)'(capture) - (RAW+1)'(pop);
      end
   end

   assert property (@(posedge clk) disable iff (reset)
      !(capture && !pop && (rsp_count == (RAW+1)'(RSP_DEPTH))));

endmodule
